// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-scan debounce and one strobe per accepted key.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       pb_in_rst,
    input  logic [3:0] pad_col_in,
    output logic [3:0] pad_row_scn,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [4:0] CAND_NONE = 5'h10;

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    col_s1_q, col_s2_q;
    logic          acc_found_q, acc_found_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [4:0]    prev_q, prev_d;
    logic [3:0]    stable_q, stable_d;

    state_t        state_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;

    logic          sample;
    logic          end_of_scan;
    logic          row_hit;
    logic [1:0]    row_col;
    logic          prior_found;
    logic          cand_found;
    logic [3:0]    cand_code;
    logic [4:0]    cand;
    logic          debounced;

    assign pad_row_scn = ~(4'b0001 << row_q);
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;

    assign sample      = (dwell_q == DW'(SCAN_DIV - 1));
    assign end_of_scan = sample && (row_q == 2'd3);

    // Lowest active column of the row being driven; descending loop lets the lowest index win.
    always_comb begin
        row_hit = 1'b0;
        row_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s2_q[c]) begin
                row_hit = 1'b1;
                row_col = 2'(c);
            end
        end
    end

    // A hit from an earlier row in this scan outranks anything found on later rows.
    assign prior_found = (row_q != 2'd0) && acc_found_q;
    assign cand_found  = prior_found || row_hit;
    assign cand_code   = prior_found ? acc_code_q : {row_q, row_col};
    assign cand        = cand_found ? {1'b0, cand_code} : CAND_NONE;

    always_comb begin
        dwell_d     = sample ? '0 : dwell_q + DW'(1);
        row_d       = sample ? row_q + 2'd1 : row_q;
        acc_found_d = sample ? cand_found : acc_found_q;
        acc_code_d  = sample ? cand_code : acc_code_q;
        prev_d      = end_of_scan ? cand : prev_q;
        stable_d    = stable_q;
        if (end_of_scan) begin
            if (cand != prev_q) begin
                stable_d = 4'd1;
            end else if (stable_q != 4'(DEBOUNCE_SCANS)) begin
                stable_d = stable_q + 4'd1;
            end
        end
    end

    assign debounced = end_of_scan && (stable_d == 4'(DEBOUNCE_SCANS));

    always_ff @(posedge clk or posedge pb_in_rst) begin
        if (pb_in_rst) begin
            dwell_q     <= '0;
            row_q       <= 2'd0;
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            acc_found_q <= 1'b0;
            acc_code_q  <= 4'd0;
            prev_q      <= CAND_NONE;
            stable_q    <= 4'd0;
        end else begin
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            col_s1_q    <= pad_col_in;
            col_s2_q    <= col_s1_q;
            acc_found_q <= acc_found_d;
            acc_code_q  <= acc_code_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    logic [RW-1:0] rep_q;
`endif

    // Key events are decided only on scans where the candidate has been stable long enough.
    always_ff @(posedge clk or posedge pb_in_rst) begin
        if (pb_in_rst) begin
            state_q     <= IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (debounced && !cand[4]) begin
                        key_code_q  <= cand[3:0];
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state_q     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
`endif
                    end
                end
                PRESSED: begin
                    if (debounced) begin
                        if (cand[4]) begin
                            key_held_q <= 1'b0;
                            state_q    <= IDLE;
                        end else if (cand[3:0] != key_code_q) begin
                            key_code_q  <= cand[3:0];
                            key_valid_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_q       <= '0;
`endif
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (rep_q == RW'(REPEAT_SCANS - 1)) begin
                                key_valid_q <= 1'b1;
                                rep_q       <= '0;
                            end else begin
                                rep_q <= rep_q + RW'(1);
                            end
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised scoreboard bench for keypad_scanner; a scan-level model predicts strobes.
// Honours KEYPAD_REPEAT_EN the same way the design does.
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DB   = 4;
    localparam int RS   = 8;
    localparam int SCAN = 4 * SD;
    localparam int NONE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  colIn;
    logic [3:0]  rowScn;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyHeld;
    logic [15:0] mask;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic prevValid = 1'b0;

    typedef struct {
        int code;
        int cyc;
    } ev_t;
    ev_t expq[$];

    int mPrev, mCnt, mCode, mRep, mScan;
    bit mPressed;

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS(RS)
    ) dut (
        .clk(clk),
        .pb_in_rst(rst),
        .pad_col_in(colIn),
        .pad_row_scn(rowScn),
        .key_code(keyCode),
        .key_valid(keyValid),
        .key_held(keyHeld)
    );

    always #5 clk = ~clk;

    // Electrical model of the matrix: a pressed key pulls its column low when its row is driven.
    always_comb begin
        colIn = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rowScn[r] && mask[r*4+c]) colIn[c] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc = 0;
        else cyc = cyc + 1;
    end

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return NONE;
    endfunction

    task automatic modelReset();
        mPrev = NONE; mCnt = 0; mPressed = 0; mCode = 0; mRep = 0; mScan = 0;
        expq.delete();
    endtask

    task automatic expectEvent(input int code);
        ev_t e;
        e.code = code;
        e.cyc  = mScan * SCAN;
        expq.push_back(e);
    endtask

    task automatic modelScan(input logic [15:0] m);
        int cand;
        cand = lowest(m);
        if (cand == mPrev) mCnt = (mCnt < DB) ? mCnt + 1 : DB;
        else mCnt = 1;
        mPrev = cand;
        mScan++;
        if (mCnt == DB) begin
            if (!mPressed) begin
                if (cand != NONE) begin
                    mPressed = 1; mCode = cand; mRep = 0; expectEvent(cand);
                end
            end else if (cand == NONE) begin
                mPressed = 0;
            end else if (cand != mCode) begin
                mCode = cand; mRep = 0; expectEvent(cand);
            end else begin
`ifdef KEYPAD_REPEAT_EN
                mRep++;
                if (mRep == RS) begin
                    mRep = 0; expectEvent(cand);
                end
`endif
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One full scan with a constant set of pressed keys; mask changes right after a scan boundary.
    task automatic applyStimulus(input logic [15:0] m, input int scans);
        for (int s = 0; s < scans; s++) begin
            mask = m;
            repeat (SCAN) @(posedge clk);
            #1;
            modelScan(m);
            checkOutput("key_held", int'(keyHeld), int'(mPressed));
        end
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    // Scoreboard monitor: every strobe must match the oldest predicted event in code and timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (keyValid) begin
                total++;
                if (prevValid) begin
                    bad++;
                    $display("[TB] FAIL valid_consecutive: got 1 expected 0 at cyc %0d", cyc);
                end
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_strobe: got code %0d at cyc %0d expected none", keyCode, cyc);
                end else begin
                    ev_t e;
                    e = expq.pop_front();
                    if (int'(keyCode) != e.code || cyc != e.cyc) begin
                        bad++;
                        $display("[TB] FAIL strobe: got code %0d cyc %0d expected code %0d cyc %0d",
                                 keyCode, cyc, e.code, e.cyc);
                    end
                end
            end
            prevValid = keyValid;
        end else begin
            prevValid = 1'b0;
        end
    end

    initial begin
        logic [15:0] m;
        int kind, dur, k1, k2;
        rst  = 1'b1;
        mask = 16'h0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_row", int'(rowScn), 4'b1110);
        checkOutput("reset_valid", int'(keyValid), 0);
        releaseReset();

        // Partial debounce of key 9, then reset while row 2 is driven.
        applyStimulus(16'h1 << 9, 2);
        mask = 16'h1 << 9;
        repeat (9) @(posedge clk);
        #2;
        checkOutput("row2_drive", int'(rowScn), 4'b1011);
        rst = 1'b1;
        #1;
        checkOutput("midreset_row", int'(rowScn), 4'b1110);
        checkOutput("midreset_valid", int'(keyValid), 0);
        checkOutput("midreset_held", int'(keyHeld), 0);
        checkOutput("midreset_code", int'(keyCode), 0);
        releaseReset();

        applyStimulus(16'h1 << 9, 10);
        checkOutput("code_after_9", int'(keyCode), 9);
        applyStimulus(16'h0, 6);
        checkOutput("code_retained", int'(keyCode), 9);

        for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 16'h0001 : 16'h0000, 1);
        applyStimulus(16'h0, 5);

        applyStimulus((16'h1 << 7) | (16'h1 << 12), 6);
        checkOutput("code_multi", int'(keyCode), 7);
        applyStimulus(16'h0, 5);

        applyStimulus(16'h1 << 9, 6);
        applyStimulus(16'h1 << 2, 6);
        checkOutput("code_switch", int'(keyCode), 2);
        applyStimulus(16'h0, 5);

        applyStimulus(16'h1 << 9, 30);
        applyStimulus(16'h0, 5);

        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 3);
            dur  = $urandom_range(1, 7);
            k1   = $urandom_range(0, 15);
            k2   = $urandom_range(0, 15);
            case (kind)
                0: applyStimulus(16'h0, dur);
                1: applyStimulus(16'h1 << k1, dur);
                2: applyStimulus((16'h1 << k1) | (16'h1 << k2), dur);
                default: begin
                    m = 16'h1 << k1;
                    for (int s = 0; s < dur; s++) applyStimulus((s % 2 == 0) ? m : 16'h0, 1);
                end
            endcase
        end
        applyStimulus(16'h0, 5);

        checkOutput("final_code", int'(keyCode), mCode);
        checkOutput("pending_events", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad on the demo board, debounces it, and delivers one clean key event per press to the game-control logic in the `tetris_battle` top level. It drives `pad_row_scn` and samples `pad_col_in` directly at the board pins. Downstream logic sees a 4-bit key code, a single-cycle press strobe and a held level. Move, rotate and drop commands are built from that strobe and level.

## Interface
- `SCAN_DIV`, 1000: clk cycles each row is driven (dwell); min 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans needed to accept a state; range 1..15.
- `REPEAT_SCANS`, 64: auto-repeat period in full scans; used only when `KEYPAD_REPEAT_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `pb_in_rst`  in  1  reset; asynchronous, active-high.
- `pad_col_in`  in  4  column returns, active-low (pulled up on board), asynchronous to clk.
- `pad_row_scn`  out  4  row drive, one-hot active-low.
- `key_code`  out  4  code of last accepted key, {row[1:0], col[1:0]}.
- `key_valid`  out  1  one-cycle strobe: new key accepted (or repeat).
- `key_held`  out  1  level: accepted key currently pressed.

## Operation
- Row counter `row` cycles 0,1,2,3,0… advancing every `SCAN_DIV` cycles. `pad_row_scn = ~(4'b0001 << row)`.
- `pad_col_in` passes through a 2-FF synchronizer. It is sampled on the last cycle of each row dwell, which allows settling time.
- Per-scan candidate: the first active column found. Rows are taken in order 0→3 and columns 0→3 within a row. The lowest index wins on multiple presses. A scan with no active column gives candidate NONE.
- End of scan is the row-3 sample. Candidate is compared with the previous scan's candidate:
  - Equal: `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`.
  - Different: `stable_cnt` = 1.
- FSM, 2 states:
  - IDLE: `key_held`=0. When `stable_cnt` reaches `DEBOUNCE_SCANS` with candidate ≠ NONE: load `key_code`, pulse `key_valid`, go to PRESSED.
  - PRESSED: `key_held`=1.
    - If stable candidate is NONE for `DEBOUNCE_SCANS` scans: go to IDLE, no strobe, `key_code` retained.
    - If stable candidate is a different key: load the new code, pulse `key_valid`, stay in PRESSED.
    - Same key held: no further strobes, except under the configuration option below.
- Bounce shorter than `DEBOUNCE_SCANS` scans produces no event and no state change.

## Timing
- Reset (async assert, sync release): `pad_row_scn`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, row=0, dwell counter=0, `stable_cnt`=0, previous candidate=NONE, FSM=IDLE.
- One full scan = 4·`SCAN_DIV` cycles.
- `key_valid` and the `key_code`/`key_held` update are registered. They appear 1 cycle after the end-of-scan sample at which debounce completes.
- Press-to-strobe latency, for a clean press: `DEBOUNCE_SCANS` to `DEBOUNCE_SCANS`+1 scans, +3 cycles (2 synchronizer + 1 output).
- `key_valid` is never high for two consecutive cycles.
- `key_code` is stable whenever `key_valid` is high and changes only together with a strobe.
- Reset mid-dwell or mid-debounce discards all partial state. There is no strobe after release of reset until a full debounce completes.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED with the same key stable, a repeat counter counts end-of-scan events.
  - Every `REPEAT_SCANS` scans, `key_valid` pulses again with the unchanged `key_code`.
  - The counter clears on entering PRESSED, on any key change, and on reset.
- `KEYPAD_REPEAT_EN` undefined: the repeat counter and its logic are absent; exactly one strobe per accepted key.

## Test plan
All scenarios use bench parameters `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=4, so one scan = 16 cycles.
- Reset asserted mid-dwell, while row 2 is driven → same cycle: `pad_row_scn`=1110, `key_valid`=0, `key_held`=0, `key_code`=0.
- Key row2/col1 held for 10 scans, then released for 6 scans →
  - exactly one `key_valid` strobe, with `key_code`=4'h9;
  - `key_held` goes 1 at the strobe;
  - `key_held` goes 0 after 4 quiet scans, with no strobe on release.
- Key row0/col0 toggled pressed/released on alternate scans for 8 scans → no strobe, `key_held` stays 0.
- Row1/col3 and row3/col0 pressed together for 6 scans → one strobe, `key_code`=4'h7.
- Key 4'h9 accepted, then switched directly to row0/col2 with no release gap → second strobe, `key_code`=4'h2, `key_held` stays 1 throughout.
- Key row2/col1 held for 30 scans, with `REPEAT_SCANS`=8:
  - `KEYPAD_REPEAT_EN` defined → 4 strobes, at debounce and then every 8 scans, all with `key_code`=4'h9;
  - `KEYPAD_REPEAT_EN` undefined → exactly 1 strobe.
